drum_spi_fifo_slave: RTL and testbench
======================================

Name: drum_spi_fifo_slave

Overview:
- Parametrised successor to the single-command drum SPI slave.
- Buffers drum trigger words from the trigger processor in a FIFO and serves them to the MCU one frame at a time over SPI mode 0 (CPOL=0, CPHA=0), using the DONE/LOAD handshake.
- All SPI inputs are oversampled in the FPGA clock domain, so there is no second clock domain.
- Adds configurable frame width, queue depth, simultaneous MOSI receive, and overflow accounting.

Parameters:
- DATA_W, 8, frame width in bits, shifted MSB first; legal range 2..32.
- DEPTH, 8, FIFO entries; power of two, legal range 2..64.
- OVF_W, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  FPGA system clock; must be at least 8x the sck frequency.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock from the MCU (asynchronous to clk).
- sdi  in  1  MOSI from the MCU (asynchronous to clk).
- sdo  out  1  MISO to the MCU.
- load  in  1  MCU acknowledge; a rising edge pops the presented frame.
- done  out  1  a frame is presented and ready to be clocked out.
- trig_valid  in  1  single-cycle push strobe.
- trig_data  in  DATA_W  word to enqueue, e.g. {velocity, drum_code}.
- rx_valid  out  1  one-cycle pulse; a complete MOSI frame has been received.
- rx_data  out  DATA_W  last complete MOSI frame.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- ovf_count  out  OVF_W  number of dropped pushes, saturating.
- command_sent  out  1  one-cycle pulse on each pop.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE. All outputs are 0: done, sdo, rx_valid, rx_data, fifo_level, ovf_count, command_sent.
- Input synchronisation: sck, sdi and load each pass through a 2-flop synchroniser.
  - A third flop provides edge detection: sck_rise, sck_fall, load_rise.
  - Each edge flag is a one-clk pulse.
- FIFO behaviour:
  - Push when trig_valid=1 and the FIFO is not full.
  - Push while full with no pop in the same cycle: the new word is dropped and ovf_count increments, saturating at 2^OVF_W-1.
  - Push and pop in the same cycle while full: both succeed, level is unchanged, no overflow.
  - Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: done=0, sdo=0. When the FIFO is non-empty, load the head into shift_reg, clear bit_cnt, and go to PRESENT.
  - PRESENT: done=1, sdo=shift_reg[DATA_W-1]. The MSB is valid before the first sck rise.
    - On sck_rise: sample sdi into rx_shift, bit_cnt++, go to SHIFT.
    - On load_rise: abort; see below.
  - SHIFT: done=1.
    - On sck_fall: shift_reg <<= 1, and sdo takes the new MSB.
    - On sck_rise: sample sdi, bit_cnt++.
    - On the DATA_W-th sck_rise: rx_data<=rx word, rx_valid=1 for one cycle, go to WAIT_ACK.
  - WAIT_ACK: done=1, sdo=0. On load_rise: pop, command_sent=1 for one cycle, go to IDLE.
- Abort: load_rise in PRESENT or SHIFT pops the frame and pulses command_sent. No rx_valid is generated and the partial rx word is discarded.
- Extra sck edges in WAIT_ACK or IDLE are ignored.
- load_rise in IDLE is ignored.
- Latency:
  - trig_valid into an empty FIFO in cycle N: done=1 and sdo=MSB from cycle N+2.
  - Pop to the next frame presented (FIFO still non-empty): 2 clk cycles, with done low for exactly 1 cycle. The MCU sees a fresh DONE edge.
- fifo_level reflects occupancy registered after the push/pop edge. The presented frame remains counted until popped.
- Mid-transfer reset: everything clears immediately, sdo goes to 0, and the queued frames are lost.

Test Plan:
- DATA_W=8: push 0x05, then run 8 sck cycles with sdi pattern 0xA3.
  - sdo reads 0x05 MSB-first.
  - rx_valid pulses with rx_data=0xA3.
  - Then load rise: command_sent pulses, done falls, fifo_level=0.
- Push 0x01, 0x02, 0x03 back-to-back, with no SPI activity.
  - fifo_level=3.
  - Three full transfer+load rounds return 0x01, 0x02, 0x03 in order.
  - done drops for one cycle between frames.
- DEPTH=8: push 10 words with no pops.
  - fifo_level=8, ovf_count=2.
  - The first 8 words are retained.
  - A push coincident with a pop while full leaves level=8 and ovf_count unchanged.
- Abort: load rise after 3 sck rises.
  - Frame is popped, command_sent pulses.
  - No rx_valid.
  - The next frame is presented with MSB on sdo before any sck.
- DATA_W=12, DEPTH=4: push 0xABC; 12 sck cycles yield 0xABC. Then assert rst_n=0 during SHIFT with 2 words queued: done=0, sdo=0, fifo_level=0 immediately.
- Boundary: ovf_count saturates at 255 after 300 overflow pushes. An sck burst in IDLE produces no rx_valid and sdo stays 0.

Source files
------------

// File: rtl/drum_spi_fifo_slave.sv
// Drum trigger FIFO served to an MCU over SPI mode 0 with a DONE/LOAD handshake.
// All SPI inputs are oversampled in the clk domain; frames shift MSB first.
// MOSI is captured into rx_data while a frame is clocked out on MISO.
module drum_spi_fifo_slave #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int OVF_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sck,
  input  logic                     sdi,
  output logic                     sdo,
  input  logic                     load,
  output logic                     done,
  input  logic                     trig_valid,
  input  logic [DATA_W-1:0]        trig_data,
  output logic                     rx_valid,
  output logic [DATA_W-1:0]        rx_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [OVF_W-1:0]         ovf_count,
  output logic                     command_sent
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, PRESENT, SHIFT, WAIT_ACK} state_e;

  state_e              state_q, state_d;
  logic [2:0]          sck_sync_q;
  logic [1:0]          sdi_sync_q;
  logic [2:0]          load_sync_q;
  logic                sck_rise, sck_fall, load_rise, sdi_s;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic [OVF_W-1:0]    ovf_q;
  logic                fifo_empty, fifo_full, push, pop, drop;

  logic [DATA_W-1:0]   shift_reg_q, rx_shift_q, rx_data_q;
  logic [CW-1:0]       bit_cnt_q;
  logic                last_bit, rx_valid_q, command_sent_q;

  // Two-flop synchronisers plus one extra flop on sck/load for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      sdi_sync_q  <= '0;
      load_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], sck};
      sdi_sync_q  <= {sdi_sync_q[0], sdi};
      load_sync_q <= {load_sync_q[1:0], load};
    end
  end

  assign sck_rise  =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall  = ~sck_sync_q[1] &  sck_sync_q[2];
  assign load_rise =  load_sync_q[1] & ~load_sync_q[2];
  assign sdi_s     =  sdi_sync_q[1];

  // A pop retires the presented frame, so a push while full succeeds if it coincides with one.
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(DEPTH));
  assign pop        = load_rise && (state_q != IDLE);
  assign push       = trig_valid && (!fifo_full || pop);
  assign drop       = trig_valid && fifo_full && !pop;
  assign last_bit   = sck_rise && (state_q == SHIFT) && (bit_cnt_q == CW'(DATA_W - 1));

  // FIFO pointers, occupancy and saturating overflow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      if (drop && (ovf_q != '1)) ovf_q <= ovf_q + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= trig_data;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; LOAD takes priority over a coincident sck edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!fifo_empty) state_d = PRESENT;
      PRESENT:  if (load_rise) state_d = IDLE;
                else if (sck_rise) state_d = SHIFT;
      SHIFT:    if (load_rise) state_d = IDLE;
                else if (last_bit) state_d = WAIT_ACK;
      WAIT_ACK: if (load_rise) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Handshake outputs: MISO carries the shift register MSB only while a frame is live.
  always_comb begin
    done = 1'b0;
    sdo  = 1'b0;
    case (state_q)
      PRESENT, SHIFT: begin
        done = 1'b1;
        sdo  = shift_reg_q[DATA_W-1];
      end
      WAIT_ACK: done = 1'b1;
      default: ;
    endcase
  end

  // Shift datapath: head load in IDLE, MOSI sampled on rise, MISO advanced on fall.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (!fifo_empty) begin
        shift_reg_q <= mem[rd_ptr_q];
        rx_shift_q  <= '0;
        bit_cnt_q   <= '0;
      end
      PRESENT, SHIFT: if (!load_rise) begin
        if (sck_rise) begin
          rx_shift_q <= {rx_shift_q[DATA_W-2:0], sdi_s};
          bit_cnt_q  <= bit_cnt_q + 1'b1;
        end else if (sck_fall && (state_q == SHIFT)) begin
          shift_reg_q <= {shift_reg_q[DATA_W-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Completed-frame and pop strobes, plus the last received MOSI word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      command_sent_q <= 1'b0;
    end else begin
      rx_valid_q     <= last_bit && !load_rise;
      command_sent_q <= pop;
      if (last_bit && !load_rise) rx_data_q <= {rx_shift_q[DATA_W-2:0], sdi_s};
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign fifo_level   = level_q;
  assign ovf_count    = ovf_q;
  assign command_sent = command_sent_q;

endmodule

// File: tb/tb_drum_spi_fifo_slave.sv
// Scoreboard bench for drum_spi_fifo_slave: an 8-bit/depth-8 instance and a
// 12-bit/depth-4 instance share the SPI pins; only one holds frames at a time.
module tb_drum_spi_fifo_slave;

  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, sdi = 1'b0, load = 1'b0;
  always #5 clk = ~clk;

  logic        tv8 = 1'b0, sdo8, done8, rxv8, cs8;
  logic [7:0]  td8 = '0, rxd8, ovf8;
  logic [3:0]  lvl8;
  logic        tv12 = 1'b0, sdo12, done12, rxv12, cs12;
  logic [11:0] td12 = '0, rxd12;
  logic [7:0]  ovf12;
  logic [2:0]  lvl12;

  drum_spi_fifo_slave #(.DATA_W(8), .DEPTH(8), .OVF_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .sdo(sdo8), .load(load), .done(done8),
    .trig_valid(tv8), .trig_data(td8), .rx_valid(rxv8), .rx_data(rxd8),
    .fifo_level(lvl8), .ovf_count(ovf8), .command_sent(cs8));

  drum_spi_fifo_slave #(.DATA_W(12), .DEPTH(4), .OVF_W(8)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .sdo(sdo12), .load(load), .done(done12),
    .trig_valid(tv12), .trig_data(td12), .rx_valid(rxv12), .rx_data(rxd12),
    .fifo_level(lvl12), .ovf_count(ovf12), .command_sent(cs12));

  int checks = 0, passes = 0;
  logic [31:0] exp8_q[$], exp12_q[$], rx8_q[$], rx12_q[$];
  int mlvl8 = 0, movf8 = 0, mlvl12 = 0;
  int cs8_cnt = 0, cs12_cnt = 0, rx8_cnt = 0, rx12_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitors: received frames are popped from the scoreboard as they appear.
  always @(negedge clk) begin
    if (rxv8) begin
      rx8_cnt++;
      if (rx8_q.size() == 0) chk("rx8_unexpected", rx8_q.size(), 1);
      else chk("rx8_data", {24'h0, rxd8}, rx8_q.pop_front());
    end
    if (rxv12) begin
      rx12_cnt++;
      if (rx12_q.size() == 0) chk("rx12_unexpected", rx12_q.size(), 1);
      else chk("rx12_data", {20'h0, rxd12}, rx12_q.pop_front());
    end
    if (cs8)  cs8_cnt++;
    if (cs12) cs12_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_sdo(input bit sel);
    return sel ? sdo12 : sdo8;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? done12 : done8;
  endfunction
  function automatic int get_lvl(input bit sel);
    return sel ? int'(lvl12) : int'(lvl8);
  endfunction

  task automatic push(input bit sel, input logic [31:0] d);
    if (sel) begin tv12 = 1'b1; td12 = d[11:0]; end
    else     begin tv8  = 1'b1; td8  = d[7:0];  end
    tick();
    tv8 = 1'b0; tv12 = 1'b0;
    if (sel) begin
      if (mlvl12 < 4) begin exp12_q.push_back(d); mlvl12++; end
    end else begin
      if (mlvl8 < 8) begin exp8_q.push_back(d); mlvl8++; end
      else if (movf8 < 255) movf8++;
    end
  endtask

  // Clock nbits SPI mode-0 cycles, reading MISO just before each rising sck.
  task automatic xfer(input bit sel, input int nbits, input int width,
                      input logic [31:0] mosi, output logic [31:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      sdi = mosi[width-1-i];
      repeat (4) tick();
      miso[width-1-i] = get_sdo(sel);
      sck = 1'b1;
      repeat (4) tick();
      sck = 1'b0;
    end
    repeat (4) tick();
  endtask

  // Raise LOAD, count cycles with DONE low, and retire the head of the scoreboard.
  task automatic do_load(input bit sel, input string tag);
    int c0, lows, explows, ml;
    logic [31:0] dummy;
    c0 = sel ? cs12_cnt : cs8_cnt;
    lows = 0;
    load = 1'b1;
    repeat (10) begin
      tick();
      if (get_done(sel) == 1'b0) lows++;
    end
    load = 1'b0;
    repeat (4) tick();
    if (sel) begin dummy = exp12_q.pop_front(); mlvl12--; ml = mlvl12; end
    else     begin dummy = exp8_q.pop_front();  mlvl8--;  ml = mlvl8;  end
    explows = (ml > 0) ? 1 : 8;
    chk({tag, "_cmd_sent"}, (sel ? cs12_cnt : cs8_cnt) - c0, 1);
    chk({tag, "_done_low"}, lows, explows);
    chk({tag, "_level"}, get_lvl(sel), ml);
  endtask

  task automatic round(input bit sel, input int width, input logic [31:0] mosi, input string tag);
    logic [31:0] m, expf;
    expf = sel ? exp12_q[0] : exp8_q[0];
    if (sel) rx12_q.push_back(mosi); else rx8_q.push_back(mosi);
    xfer(sel, width, width, mosi, m);
    chk({tag, "_miso"}, m, expf);
    do_load(sel, tag);
  endtask

  initial begin
    logic [31:0] m;
    int c0, r0, bad;

    // Reset state
    repeat (3) tick();
    chk("rst_done", done8, 0);
    chk("rst_sdo", sdo8, 0);
    chk("rst_rx_valid", rxv8, 0);
    chk("rst_rx_data", rxd8, 0);
    chk("rst_level", lvl8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_cmd_sent", cs8, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single frame with presentation latency
    push(0, 32'h05);
    chk("lat_n1_done", done8, 0);
    tick();
    chk("lat_n2_done", done8, 1);
    chk("lat_n2_sdo", sdo8, 0);
    chk("lat_level", lvl8, 1);
    round(0, 8, 32'hA3, "t1");

    // Three queued frames in order
    push(0, 32'h01); push(0, 32'h02); push(0, 32'h03);
    repeat (2) tick();
    chk("t2_level", lvl8, 3);
    round(0, 8, 32'h5C, "t2a");
    round(0, 8, 32'h81, "t2b");
    round(0, 8, 32'h7E, "t2c");

    // Overflow and simultaneous push/pop while full
    for (int i = 0; i < 10; i++) push(0, 32'h10 + i);
    repeat (2) tick();
    chk("t3_level", lvl8, 8);
    chk("t3_ovf", ovf8, movf8);
    chk("t3_msb", sdo8, 0);
    c0 = cs8_cnt;
    load = 1'b1;
    tick(); tick();
    tv8 = 1'b1; td8 = 8'h55;
    tick();
    tv8 = 1'b0;
    repeat (7) tick();
    load = 1'b0;
    repeat (4) tick();
    m = exp8_q.pop_front();
    exp8_q.push_back(32'h55);
    chk("t3_pp_cmd_sent", cs8_cnt - c0, 1);
    chk("t3_pp_level", lvl8, 8);
    chk("t3_pp_ovf", ovf8, 2);
    for (int i = 0; i < 8; i++) round(0, 8, 32'h3A + i * 7, "t3_drain");

    // Abort after three sck rises
    push(0, 32'h3C); push(0, 32'hC3);
    repeat (2) tick();
    r0 = rx8_cnt;
    xfer(0, 3, 8, 32'hFF, m);
    chk("abort_bits", m[7:5], 3'b001);
    do_load(0, "abort");
    chk("abort_no_rx", rx8_cnt - r0, 0);
    chk("abort_next_done", done8, 1);
    chk("abort_next_msb", sdo8, 1);
    round(0, 8, 32'h96, "abort_next");

    // Overflow counter saturation
    for (int i = 0; i < 308; i++) push(0, i);
    repeat (2) tick();
    chk("sat_ovf", ovf8, 255);
    chk("sat_model_ovf", ovf8, movf8);
    chk("sat_level", lvl8, 8);
    repeat (8) do_load(0, "sat_drain");

    // sck burst while idle
    r0 = rx8_cnt;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      sdi = 1'($urandom_range(0, 1));
      sck = 1'b1;
      repeat (4) begin tick(); if (sdo8 !== 1'b0 || done8 !== 1'b0) bad++; end
      sck = 1'b0;
      repeat (4) begin tick(); if (sdo8 !== 1'b0 || done8 !== 1'b0) bad++; end
    end
    chk("idle_sdo_done", bad, 0);
    chk("idle_no_rx", rx8_cnt - r0, 0);

    // 12-bit instance, then reset in the middle of a shift
    push(1, 32'hABC);
    repeat (2) tick();
    chk("w12_done", done12, 1);
    round(1, 12, 32'h5A5, "w12");
    push(1, 32'h123); push(1, 32'h456);
    repeat (2) tick();
    xfer(1, 4, 12, 32'hFFF, m);
    chk("w12_partial", m[11:8], 4'b0001);
    chk("w12_pre_rst_level", lvl12, 2);
    chk("w12_pre_rst_done", done12, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", done12, 0);
    chk("mid_rst_sdo", sdo12, 0);
    chk("mid_rst_level", lvl12, 0);
    chk("mid_rst_rx_data", rxd12, 0);
    exp12_q.delete();
    mlvl12 = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_done", done12, 0);
    chk("post_rst_level", lvl12, 0);

    chk("rx8_all_seen", rx8_q.size(), 0);
    chk("rx12_all_seen", rx12_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
